// File: rtl/decode_phase_sequencer_if.sv
// Requester and SRAM-side signals of the decode phase sequencer.
// The sequencer uses the slave view; the surrounding logic uses the master view.
interface decode_phase_sequencer_if;
  logic        uart_rx;
  logic [17:0] uart_address;
  logic [15:0] uart_write_data;
  logic        uart_we_n;
  logic [17:0] m2_address;
  logic [15:0] m2_write_data;
  logic        m2_we_n;
  logic        m2_finish;
  logic [17:0] m1_address;
  logic [15:0] m1_write_data;
  logic        m1_we_n;
  logic        m1_finish;
  logic [17:0] vga_address;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;
  logic        uart_rx_initialize;
  logic        uart_rx_enable;
  logic        m2_start;
  logic        m1_start;
  logic        vga_enable;
  logic [2:0]  phase;
  logic        timeout_error;

  modport master (
    output uart_rx, uart_address, uart_write_data, uart_we_n,
    output m2_address, m2_write_data, m2_we_n, m2_finish,
    output m1_address, m1_write_data, m1_we_n, m1_finish,
    output vga_address,
    input  sram_address, sram_write_data, sram_we_n,
    input  uart_rx_initialize, uart_rx_enable, m2_start, m1_start,
    input  vga_enable, phase, timeout_error
  );

  modport slave (
    input  uart_rx, uart_address, uart_write_data, uart_we_n,
    input  m2_address, m2_write_data, m2_we_n, m2_finish,
    input  m1_address, m1_write_data, m1_we_n, m1_finish,
    input  vga_address,
    output sram_address, sram_write_data, sram_we_n,
    output uart_rx_initialize, uart_rx_enable, m2_start, m1_start,
    output vga_enable, phase, timeout_error
  );
endinterface

// File: rtl/decode_phase_sequencer.sv
// Decode flow scheduler: UART load -> M2 -> M1 -> VGA, owning and arbitrating the SRAM port.
// One shared saturating counter serves as UART idle timer and milestone watchdog.
module decode_phase_sequencer #(
  parameter int UART_TIMEOUT = 50_000_000,
  parameter int MS_TIMEOUT   = 2**24,
  parameter int CNT_W        = 26
) (
  input logic Clock_50,
  input logic Reset,
  decode_phase_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] UART_LAST = CNT_W'(UART_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MS_LAST   = CNT_W'(MS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UART_RX = 3'd1,
    S_GAP_A   = 3'd2,
    S_M2      = 3'd3,
    S_GAP_B   = 3'd4,
    S_M1      = 3'd5,
    S_GAP_C   = 3'd6
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             rx_init, rx_init_nx;
  logic             rx_en, rx_en_nx;
  logic             m2_start, m2_start_nx;
  logic             m1_start, m1_start_nx;
  logic             vga_en, vga_en_nx;
  logic             err, err_nx;
  logic [17:0]      sram_address;
  logic [15:0]      sram_write_data;
  logic             sram_we_n;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rx_init  <= 1'b0;
      rx_en    <= 1'b0;
      m2_start <= 1'b0;
      m1_start <= 1'b0;
      vga_en   <= 1'b1;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rx_init  <= rx_init_nx;
      rx_en    <= rx_en_nx;
      m2_start <= m2_start_nx;
      m1_start <= m1_start_nx;
      vga_en   <= vga_en_nx;
      err      <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt_inc;
    rx_init_nx  = 1'b0;
    rx_en_nx    = rx_en;
    m2_start_nx = m2_start;
    m1_start_nx = m1_start;
    vga_en_nx   = vga_en;
    err_nx      = err;
    case (state)
      S_IDLE: begin
        cnt_nx = cnt;
        if (!bus.uart_rx) begin
          state_nx   = S_UART_RX;
          cnt_nx     = '0;
          vga_en_nx  = 1'b0;
          rx_init_nx = 1'b1;
        end
      end
      S_UART_RX: begin
        rx_en_nx = 1'b1;
        // A write is activity: it restarts the idle window even on the last cycle.
        if (!bus.uart_we_n) begin
          cnt_nx = '0;
        end else if (cnt == UART_LAST) begin
          rx_en_nx = 1'b0;
          state_nx = S_GAP_A;
        end
      end
      S_GAP_A: begin
        state_nx    = S_M2;
        cnt_nx      = '0;
        m2_start_nx = 1'b1;
      end
      S_M2: begin
        if (bus.m2_finish) begin
          m2_start_nx = 1'b0;
          state_nx    = S_GAP_B;
        end else if (cnt == MS_LAST) begin
          m2_start_nx = 1'b0;
          err_nx      = 1'b1;
          state_nx    = S_GAP_C;
        end
      end
      S_GAP_B: begin
        state_nx    = S_M1;
        cnt_nx      = '0;
        m1_start_nx = 1'b1;
      end
      S_M1: begin
        if (bus.m1_finish) begin
          m1_start_nx = 1'b0;
          state_nx    = S_GAP_C;
        end else if (cnt == MS_LAST) begin
          m1_start_nx = 1'b0;
          err_nx      = 1'b1;
          state_nx    = S_GAP_C;
        end
      end
      S_GAP_C: begin
        state_nx  = S_IDLE;
        vga_en_nx = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Gaps fall through to the idle bus: no owner, no write.
  always_comb begin
    sram_address    = '0;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    case (state)
      S_IDLE: sram_address = bus.vga_address;
      S_UART_RX: begin
        sram_address    = bus.uart_address;
        sram_write_data = bus.uart_write_data;
        sram_we_n       = bus.uart_we_n;
      end
      S_M2: begin
        sram_address    = bus.m2_address;
        sram_write_data = bus.m2_write_data;
        sram_we_n       = bus.m2_we_n;
      end
      S_M1: begin
        sram_address    = bus.m1_address;
        sram_write_data = bus.m1_write_data;
        sram_we_n       = bus.m1_we_n;
      end
      default: ;
    endcase
  end

  assign bus.sram_address       = sram_address;
  assign bus.sram_write_data    = sram_write_data;
  assign bus.sram_we_n          = sram_we_n;
  assign bus.uart_rx_initialize = rx_init;
  assign bus.uart_rx_enable     = rx_en;
  assign bus.m2_start           = m2_start;
  assign bus.m1_start           = m1_start;
  assign bus.vga_enable         = vga_en;
  assign bus.phase              = state;
  assign bus.timeout_error      = err;

endmodule

// File: tb/tb_decode_phase_sequencer.sv
// Bench for decode_phase_sequencer: vector table, directed corner sequences and random traffic,
// all checked every cycle against a phase-level reference model.
module tb_decode_phase_sequencer;
  localparam int UT = 20;
  localparam int MS = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_phase_sequencer_if bus ();

  decode_phase_sequencer #(
    .UART_TIMEOUT(UT),
    .MS_TIMEOUT  (MS),
    .CNT_W       (26)
  ) u_dut (
    .Clock_50(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which phase we are in, whether it is the first cycle of the load,
  // how many quiet load cycles have elapsed, and how long the current milestone has run.
  int m_phase = 0;
  bit m_first = 1'b0;
  int m_silent = 0;
  int m_age = 0;
  bit m_err = 1'b0;
  bit model_valid = 1'b0;
  int init_seen = 0;

  typedef struct {
    logic        rx;
    logic        we_n;
    logic [17:0] vga_a;
    logic [17:0] u_a;
    logic [15:0] u_d;
    logic [2:0]  e_phase;
    logic [17:0] e_addr;
    logic [15:0] e_data;
    logic        e_we;
    logic        e_init;
    logic        e_rxen;
    logic        e_vga;
  } vec_t;

  vec_t vecs[6];
  bit   tbl_on = 1'b0;
  vec_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [17:0] ea;
    logic [15:0] ed;
    logic        ew;
    ea = '0; ed = '0; ew = 1'b1;
    case (m_phase)
      0: ea = bus.vga_address;
      1: begin ea = bus.uart_address; ed = bus.uart_write_data; ew = bus.uart_we_n; end
      3: begin ea = bus.m2_address; ed = bus.m2_write_data; ew = bus.m2_we_n; end
      5: begin ea = bus.m1_address; ed = bus.m1_write_data; ew = bus.m1_we_n; end
      default: ;
    endcase
    chk("model_phase", bus.phase, m_phase);
    chk("model_m2_start", bus.m2_start, m_phase == 3);
    chk("model_m1_start", bus.m1_start, m_phase == 5);
    chk("model_vga_enable", bus.vga_enable, m_phase == 0);
    chk("model_rx_init", bus.uart_rx_initialize, (m_phase == 1) && m_first);
    chk("model_rx_enable", bus.uart_rx_enable, (m_phase == 1) && !m_first);
    chk("model_timeout_error", bus.timeout_error, m_err);
    chk("model_sram_address", bus.sram_address, ea);
    chk("model_sram_data", bus.sram_write_data, ed);
    chk("model_sram_we_n", bus.sram_we_n, ew);
  endtask

  task automatic compare_table();
    chk("tbl_phase", bus.phase, cur.e_phase);
    chk("tbl_sram_address", bus.sram_address, cur.e_addr);
    chk("tbl_sram_data", bus.sram_write_data, cur.e_data);
    chk("tbl_sram_we_n", bus.sram_we_n, cur.e_we);
    chk("tbl_rx_init", bus.uart_rx_initialize, cur.e_init);
    chk("tbl_rx_enable", bus.uart_rx_enable, cur.e_rxen);
    chk("tbl_vga_enable", bus.vga_enable, cur.e_vga);
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_first = 1'b0; m_silent = 0; m_age = 0; m_err = 1'b0;
      model_valid = 1'b1;
    end else begin
      case (m_phase)
        0: if (!bus.uart_rx) begin m_phase = 1; m_first = 1'b1; m_silent = 0; end
        1: begin
          m_first = 1'b0;
          if (!bus.uart_we_n) m_silent = 0;
          else m_silent++;
          if (m_silent == UT) m_phase = 2;
        end
        2: begin m_phase = 3; m_age = 0; end
        3: begin
          if (bus.m2_finish) m_phase = 4;
          else begin
            m_age++;
            if (m_age == MS) begin m_phase = 6; m_err = 1'b1; end
          end
        end
        4: begin m_phase = 5; m_age = 0; end
        5: begin
          if (bus.m1_finish) m_phase = 6;
          else begin
            m_age++;
            if (m_age == MS) begin m_phase = 6; m_err = 1'b1; end
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (model_valid) compare_model();
    if (tbl_on) compare_table();
    if (bus.uart_rx_initialize === 1'b1) init_seen++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_phase(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (bus.phase !== 3'(target)) begin
      if (n >= bound) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: phase %0d not reached within %0d cycles (at %0d)", name, target, bound, bus.phase);
        return;
      end
      cycle();
      n++;
    end
  endtask

  task automatic start_load();
    bus.uart_rx = 1'b0;
    cycle();
    bus.uart_rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b1, 18'h12345, 18'h00111, 16'h1111, 3'd0, 18'h12345, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 18'h3ffff, 18'h00222, 16'h2222, 3'd0, 18'h3ffff, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 18'h00abc, 18'h00333, 16'h3333, 3'd0, 18'h00abc, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 18'h00def, 18'h00444, 16'h4444, 3'd1, 18'h00444, 16'h4444, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 18'h00000, 18'h00555, 16'h5555, 3'd1, 18'h00555, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 18'h00001, 18'h00666, 16'h6666, 3'd1, 18'h00666, 16'h6666, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.uart_rx = 1'b1; bus.uart_address = '0; bus.uart_write_data = '0; bus.uart_we_n = 1'b1;
    bus.m2_address = 18'h0a0a0; bus.m2_write_data = 16'hb2b2; bus.m2_we_n = 1'b1; bus.m2_finish = 1'b0;
    bus.m1_address = 18'h0c0c0; bus.m1_write_data = 16'hd1d1; bus.m1_we_n = 1'b1; bus.m1_finish = 1'b0;
    bus.vga_address = 18'h2a5a5;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) cycle();
    chk("rst_phase", bus.phase, 0);
    chk("rst_vga_enable", bus.vga_enable, 1);
    chk("rst_m2_start", bus.m2_start, 0);
    chk("rst_m1_start", bus.m1_start, 0);
    chk("rst_sram_we_n", bus.sram_we_n, 1);
    chk("rst_sram_address", bus.sram_address, 18'h2a5a5);
    rst = 1'b0;

    // Vector table: idle mux, load entry, first load cycles
    init_seen = 0;
    tbl_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cur = vecs[i];
      bus.uart_rx = cur.rx; bus.uart_we_n = cur.we_n; bus.vga_address = cur.vga_a;
      bus.uart_address = cur.u_a; bus.uart_write_data = cur.u_d;
      cycle();
    end
    tbl_on = 1'b0;
    bus.uart_rx = 1'b1;

    // Five writes ten cycles apart, then quiet until the load times out
    for (int w = 0; w < 5; w++) begin
      bus.uart_we_n = 1'b1;
      repeat (9) cycle();
      bus.uart_address = 18'($urandom); bus.uart_write_data = 16'($urandom); bus.uart_we_n = 1'b0;
      cycle();
    end
    bus.uart_we_n = 1'b1;
    n = 0;
    while (bus.phase !== 3'd2 && n < 200) begin cycle(); n++; end
    chk("uart_gap_delay", n, UT);
    chk("uart_init_pulses", init_seen, 1);

    // M2 finishes after 30 cycles; stray M1 finish ignored
    cycle();
    chk("m2_entry_start", bus.m2_start, 1);
    for (int i = 0; i < 30; i++) begin
      bus.m1_finish = (i == 10);
      cycle();
    end
    bus.m1_finish = 1'b0;
    chk("stray_m1_finish_phase", bus.phase, 3);
    bus.m2_finish = 1'b1; bus.m2_we_n = 1'b0; bus.m1_we_n = 1'b0;
    cycle();
    bus.m2_finish = 1'b0;
    chk("m2_finish_start_low", bus.m2_start, 0);
    chk("gap_b_phase", bus.phase, 4);
    chk("gap_b_we_n", bus.sram_we_n, 1);
    chk("gap_b_address", bus.sram_address, 0);
    cycle();
    bus.m2_we_n = 1'b1; bus.m1_we_n = 1'b1;
    chk("m1_start_after_gap", bus.m1_start, 1);
    chk("m1_phase", bus.phase, 5);

    // M1 never finishes: watchdog
    n = 0;
    while (bus.m1_start === 1'b1 && n < 200) begin
      bus.m2_finish = (n == 7);
      cycle();
      n++;
    end
    bus.m2_finish = 1'b0;
    chk("m1_watchdog_cycles", n, MS);
    chk("m1_watchdog_error", bus.timeout_error, 1);
    chk("m1_watchdog_phase", bus.phase, 6);
    cycle();
    chk("back_to_idle", bus.phase, 0);
    chk("idle_vga_enable", bus.vga_enable, 1);

    // Second full run keeps the sticky error
    start_load();
    wait_phase(3, 100, "run2_m2");
    repeat (5) cycle();
    bus.m2_finish = 1'b1; cycle(); bus.m2_finish = 1'b0;
    wait_phase(5, 5, "run2_m1");
    repeat (5) cycle();
    bus.m1_finish = 1'b1; cycle(); bus.m1_finish = 1'b0;
    wait_phase(0, 5, "run2_idle");
    chk("error_sticky", bus.timeout_error, 1);

    // Reset while M2 is writing
    start_load();
    wait_phase(3, 100, "rst_mid_m2");
    bus.m2_we_n = 1'b0;
    repeat (3) cycle();
    chk("m2_owner_we_n", bus.sram_we_n, 0);
    rst = 1'b1;
    cycle();
    chk("rst_mid_phase", bus.phase, 0);
    chk("rst_mid_m2_start", bus.m2_start, 0);
    chk("rst_mid_we_n", bus.sram_we_n, 1);
    chk("rst_mid_error_cleared", bus.timeout_error, 0);
    rst = 1'b0;
    bus.m2_we_n = 1'b1;

    // Finish on the exact watchdog expiry cycle wins
    start_load();
    wait_phase(3, 100, "race_m2");
    repeat (MS - 1) cycle();
    bus.m2_finish = 1'b1; cycle(); bus.m2_finish = 1'b0;
    chk("race_m2_phase", bus.phase, 4);
    chk("race_m2_no_error", bus.timeout_error, 0);
    wait_phase(5, 5, "race_m1");
    repeat (MS - 1) cycle();
    bus.m1_finish = 1'b1; cycle(); bus.m1_finish = 1'b0;
    chk("race_m1_phase", bus.phase, 6);
    chk("race_m1_no_error", bus.timeout_error, 0);
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst                 = ($urandom_range(0, 299) == 0);
      bus.uart_rx         = ($urandom_range(0, 7) != 0);
      bus.uart_we_n       = ($urandom_range(0, 24) != 0);
      bus.uart_address    = 18'($urandom);
      bus.uart_write_data = 16'($urandom);
      bus.m2_address      = 18'($urandom);
      bus.m2_write_data   = 16'($urandom);
      bus.m2_we_n         = 1'($urandom);
      bus.m2_finish       = ($urandom_range(0, 59) == 0);
      bus.m1_address      = 18'($urandom);
      bus.m1_write_data   = 16'($urandom);
      bus.m1_we_n         = 1'($urandom);
      bus.m1_finish       = ($urandom_range(0, 59) == 0);
      bus.vga_address     = 18'($urandom);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
